// File: rtl/lc3_loader_pkg.sv
// Shared types and constants for the LC-3 byte-stream program loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the loader state enum, the byte/word width constants and the
// reset value of cpu_hold. The CSUM_HI/CSUM_LO/ERR states exist only when
// LC3_LOADER_CHECKSUM_EN is defined.
package lc3_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // The core stays in reset from power-up until an image is loaded.
  localparam logic CPU_HOLD_RST = 1'b1;

  typedef enum logic [3:0] {
    ST_ORIG_HI,
    ST_ORIG_LO,
    ST_CNT_HI,
    ST_CNT_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_DONE
`ifdef LC3_LOADER_CHECKSUM_EN
    ,
    ST_CSUM_HI,
    ST_CSUM_LO,
    ST_ERR
`endif
  } state_t;

endpackage

// File: rtl/lc3_byte_pair.sv
// Assembles big-endian byte pairs into 16-bit words.
// Latency: word_valid is combinational with acceptance of the low byte.
// Backpressure: none of its own; the caller gates take with in_valid && in_ready.
//
// Ports:
//   clk, reset      - system clock, async active-low reset
//   clear           - synchronous return to the high-byte phase
//   take            - a byte is accepted this cycle
//   in_byte         - the accepted byte
//   word_valid/word - one-cycle strobe and {hi, lo} when the low byte is taken
module lc3_byte_pair
  import lc3_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              take,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [BYTE_W-1:0] hi_byte;
  logic              lo_phase;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_byte  <= '0;
      lo_phase <= 1'b0;
    end else if (clear) begin
      lo_phase <= 1'b0;
    end else if (take) begin
      if (!lo_phase) begin
        hi_byte <= in_byte;
      end
      lo_phase <= ~lo_phase;
    end
  end

  // The word is presented in the same cycle as the low byte so the caller
  // can register the memory write at that edge.
  assign word_valid = take & lo_phase;
  assign word       = {hi_byte, in_byte};

endmodule

// File: rtl/lc3_program_loader.sv
// Byte-stream loader writing an image into LC-3 memory, holding the CPU off until done.
// Latency: low byte accepted at edge k -> mem_we during cycle k+1 -> words_loaded at edge k+1.
// Backpressure: in_ready=1 in every receive state, 0 in DONE/ERR; one byte/cycle sustained.
//
// Optional feature macro: LC3_LOADER_CHECKSUM_EN (adds a trailing 16-bit
// checksum word, a running sum register and the CSUM_HI/CSUM_LO/ERR states).
//
// Ports:
//   clk, reset                  - system clock, async active-low reset
//   in_data/in_valid/in_ready   - byte stream input (valid/ready)
//   restart                     - pulse: DONE/ERR -> ORIG_HI
//   mem_addr/mem_data/mem_we    - direct memory write port of the core
//   cpu_hold                    - core held in reset while high
//   done/err                    - image loaded / checksum mismatch
//   words_loaded                - words written since restart or reset
module lc3_program_loader
  import lc3_loader_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [WORD_W-1:0] words_loaded
);

`ifdef LC3_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CSUM_HI;
`else
  localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

  state_t            state, state_next;
  logic              receiving;
  logic              restart_go;
  logic              accept;
  logic              word_valid;
  logic [WORD_W-1:0] pair_word;
  logic [ADDR_W-1:0] ptr;
  logic [WORD_W-1:0] remaining;
`ifdef LC3_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  logic              err_q;
`endif

  assign in_ready = reset & receiving;
  assign accept   = in_valid & in_ready;

  lc3_byte_pair u_pair (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart_go),
    .take       (accept),
    .in_byte    (in_data),
    .word_valid (word_valid),
    .word       (pair_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_ORIG_HI;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    receiving  = 1'b1;
    restart_go = 1'b0;
    case (state)
      ST_ORIG_HI: if (accept) state_next = ST_ORIG_LO;
      ST_ORIG_LO: if (accept) state_next = ST_CNT_HI;
      ST_CNT_HI:  if (accept) state_next = ST_CNT_LO;
      ST_CNT_LO: begin
        if (word_valid) begin
          state_next = (pair_word == '0) ? ST_AFTER_DATA : ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
      ST_DATA_LO: begin
        // remaining still holds the count before this word is written.
        if (word_valid) begin
          state_next = (remaining == WORD_W'(1)) ? ST_AFTER_DATA : ST_DATA_HI;
        end
      end
`ifdef LC3_LOADER_CHECKSUM_EN
      ST_CSUM_HI: if (accept) state_next = ST_CSUM_LO;
      ST_CSUM_LO: begin
        if (word_valid) begin
          state_next = (pair_word == sum) ? ST_DONE : ST_ERR;
        end
      end
      ST_ERR: begin
        receiving  = 1'b0;
        restart_go = restart;
        if (restart) state_next = ST_ORIG_HI;
      end
`endif
      ST_DONE: begin
        receiving  = 1'b0;
        restart_go = restart;
        if (restart) state_next = ST_ORIG_HI;
      end
      default: state_next = ST_ORIG_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr          <= '0;
      remaining    <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_we       <= 1'b0;
      words_loaded <= '0;
      cpu_hold     <= CPU_HOLD_RST;
      done         <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      if (word_valid && state == ST_ORIG_LO) begin
        ptr <= ADDR_W'(pair_word);
      end
      if (word_valid && state == ST_CNT_LO) begin
        remaining <= pair_word;
      end
      if (word_valid && state == ST_DATA_LO) begin
        mem_addr  <= ptr;
        mem_data  <= DATA_W'(pair_word);
        mem_we    <= 1'b1;
        ptr       <= ptr + ADDR_W'(1);
        remaining <= remaining - WORD_W'(1);
      end
      if (restart_go) begin
        ptr       <= '0;
        remaining <= '0;
      end

      if (restart_go) begin
        words_loaded <= '0;
      end else if (mem_we) begin
        words_loaded <= words_loaded + WORD_W'(1);
      end

      done     <= (state_next == ST_DONE);
      cpu_hold <= (state_next != ST_DONE);
    end
  end

`ifdef LC3_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else begin
      if (restart_go) begin
        sum <= '0;
      end else if (word_valid && state == ST_DATA_LO) begin
        sum <= sum + pair_word;
      end
      err_q <= (state_next == ST_ERR);
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_program_loader.sv
// Self-checking directed bench for lc3_program_loader.
// Latency: checks the cycle-exact write, done and words_loaded timing.
// Backpressure: exercises random in_valid gaps and bytes offered after done.
module tb_lc3_program_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  stim[$];
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  lc3_program_loader #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .restart      (restart),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write seen mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
    end
  end

  task automatic push_word(input logic [15:0] w);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  // Drive the stim queue; returns 1 ns after the edge accepting the last byte.
  task automatic send_stim(input int max_gap);
    int t;
    foreach (stim[i]) begin
      if (max_gap > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
          @(posedge clk);
          #1;
        end
      end
      in_data  = stim[i];
      in_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout byte %0d: in_ready stayed 0", i);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic build_basic();
    stim.delete();
    push_word(16'h3000);
    push_word(16'h0002);
    push_word(16'h1234);
    push_word(16'hABCD);
`ifdef LC3_LOADER_CHECKSUM_EN
    push_word(16'hBE01);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low got %b want 0", in_ready); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
    n_cmp++; if (mem_data !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_data got %h want 0000", mem_data); end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_cmp++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL reset_words got %0d want 0", words_loaded); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic(input int max_gap, input string tag);
    logic [15:0] exp_a[2];
    logic [15:0] exp_d[2];
    exp_a[0] = 16'h3000; exp_d[0] = 16'h1234;
    exp_a[1] = 16'h3001; exp_d[1] = 16'hABCD;
    wr_addr.delete();
    wr_data.delete();
    build_basic();
    send_stim(max_gap);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done got %b want 1", tag, done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL %s_cpu_hold got %b want 0", tag, cpu_hold); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_in_ready got %b want 0", tag, in_ready); end
    // Offer extra bytes after done: none may be consumed.
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL %s_extra ready=%b done=%b want 0/1", tag, in_ready, done); end
    end
    in_valid = 1'b0;
    n_cmp++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL %s_words got %0d want 2", tag, words_loaded); end
    n_cmp++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL %s_nwrites got %0d want 2", tag, wr_addr.size()); end
    for (int i = 0; i < 2 && i < wr_addr.size(); i++) begin
      n_cmp++;
      if (wr_addr[i] !== exp_a[i] || wr_data[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL %s_write%0d got %h@%h want %h@%h", tag, i, wr_data[i], wr_addr[i], exp_d[i], exp_a[i]);
      end
    end
    @(posedge clk);
    #1;
    pulse_restart();
    @(negedge clk);
    n_cmp++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL %s_restart hold=%b done=%b want 1/0", tag, cpu_hold, done); end
    n_cmp++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL %s_restart_words got %0d want 0", tag, words_loaded); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_wrap();
    wr_addr.delete();
    wr_data.delete();
    stim.delete();
    push_word(16'hFFFF);
    push_word(16'h0002);
    push_word(16'h0001);
    push_word(16'h0002);
`ifdef LC3_LOADER_CHECKSUM_EN
    push_word(16'h0003);
`endif
    send_stim(0);
    repeat (2) @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", done); end
    n_cmp++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL wrap_nwrites got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      n_cmp++; if (wr_addr[0] !== 16'hFFFF || wr_data[0] !== 16'h0001) begin n_fail++; $display("FAIL wrap_write0 got %h@%h want 0001@ffff", wr_data[0], wr_addr[0]); end
      n_cmp++; if (wr_addr[1] !== 16'h0000 || wr_data[1] !== 16'h0002) begin n_fail++; $display("FAIL wrap_write1 got %h@%h want 0002@0000", wr_data[1], wr_addr[1]); end
    end
    n_cmp++; if (words_loaded !== 16'd2) begin n_fail++; $display("FAIL wrap_words got %0d want 2", words_loaded); end
    pulse_restart();
  endtask

  task automatic test_zero_count();
    wr_addr.delete();
    wr_data.delete();
    stim.delete();
    push_word(16'h4000);
    push_word(16'h0000);
`ifdef LC3_LOADER_CHECKSUM_EN
    push_word(16'h0000);
`endif
    send_stim(0);
    @(negedge clk);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done got %b want 1", done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL zero_cpu_hold got %b want 0", cpu_hold); end
    @(negedge clk);
    n_cmp++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL zero_nwrites got %0d want 0", wr_addr.size()); end
    n_cmp++; if (words_loaded !== 16'd0) begin n_fail++; $display("FAIL zero_words got %0d want 0", words_loaded); end
    @(posedge clk);
    #1;
    pulse_restart();
  endtask

`ifdef LC3_LOADER_CHECKSUM_EN
  task automatic test_csum_err();
    stim.delete();
    push_word(16'h3000);
    push_word(16'h0001);
    push_word(16'h0005);
    push_word(16'h0006);
    send_stim(0);
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL csum_err got %b want 1", err); end
    n_cmp++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL csum_hold hold=%b done=%b want 1/0", cpu_hold, done); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL csum_in_ready got %b want 0", in_ready); end
    @(posedge clk);
    #1;
    pulse_restart();
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL csum_restart err=%b ready=%b want 0/1", err, in_ready); end
    @(posedge clk);
    #1;
  endtask
`endif

  task automatic test_reset_mid_load();
    stim.delete();
    push_word(16'h3000);
    push_word(16'h0002);
    push_word(16'h1234);
    wr_addr.delete();
    wr_data.delete();
    send_stim(0);
    @(negedge clk);
    n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 16'h3000) begin n_fail++; $display("FAIL mid_first_write we=%b addr=%h want 1/3000", mem_we, mem_addr); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0 || mem_we !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_reset ready=%b we=%b hold=%b want 0/0/1", in_ready, mem_we, cpu_hold); end
    n_cmp++; if (mem_addr !== 16'h0000 || mem_data !== 16'h0000 || words_loaded !== 16'd0) begin n_fail++; $display("FAIL mid_reset_regs addr=%h data=%h words=%0d want 0/0/0", mem_addr, mem_data, words_loaded); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags done=%b err=%b want 0/0", done, err); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_basic(0, "reload");
  endtask

  initial begin
    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    restart  = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic(0, "basic");
    test_wrap();
    test_zero_count();
`ifdef LC3_LOADER_CHECKSUM_EN
    test_csum_err();
`endif
    test_basic(3, "gaps");
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
